// File: rtl/cpu_pkg.sv
// cpu_pkg: shared front-end types and default parameters
package cpu_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int DEF_INSTR_BYTES = 4;
  typedef enum logic [1:0] {BOOT, IDLE, WAIT, HOLD} pcseq_state_t;
endpackage

// File: rtl/pc_fetch_sequencer_next_sel.sv
// pc_next_sel: next-PC priority mux, incoming redirect > pending redirect > sequential
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic             pending_i,
  input  logic [WIDTH-1:0] pend_pc_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] next_pc_o
);
  always_comb next_pc_o = redirect_i ? redirect_pc_i : pending_i ? pend_pc_i : pc_i + WIDTH'(INSTR_BYTES);
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: PC register, single-outstanding fetch handshake and decode buffer
module pc_fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int               INSTR_BYTES  = DEF_INSTR_BYTES
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic [WIDTH-1:0] instr_o,
  output logic             instr_valid_o,
  output logic [WIDTH-1:0] instr_pc_o,
  output logic [WIDTH-1:0] instr_pc4_o,
  output logic             flush_o
);
  pcseq_state_t state_q;
  logic [WIDTH-1:0] pc_q, pc_d, pend_pc_q, tgt;
  logic pending_q;
  logic imem_req_q, instr_valid_q, flush_q;
  logic [WIDTH-1:0] imem_addr_q, instr_q, instr_pc_q, instr_pc4_q;
  always_comb tgt = {redirect_pc_i[WIDTH-1:2], 2'b00};
  pc_next_sel #(.WIDTH(WIDTH), .INSTR_BYTES(INSTR_BYTES)) u_next_sel (
    .redirect_i   (redirect_i),
    .redirect_pc_i(tgt),
    .pending_i    (pending_q),
    .pend_pc_i    (pend_pc_q),
    .pc_i         (pc_q),
    .next_pc_o    (pc_d)
  );
  // A redirect during an outstanding fetch is parked until ack so the request never drops
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pend_pc_q     <= '0;
      pending_q     <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_VECTOR;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      instr_pc4_q   <= '0;
      flush_q       <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        BOOT: state_q <= IDLE;
        IDLE: begin
          if (redirect_i) begin
            pc_q    <= pc_d;
            flush_q <= 1'b1;
          end else begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack_i) begin
            imem_req_q <= 1'b0;
            pc_q       <= pc_d;
            pending_q  <= 1'b0;
            if (redirect_i || pending_q) begin
              flush_q <= redirect_i;
              state_q <= IDLE;
            end else begin
              instr_q       <= imem_rdata_i;
              instr_pc_q    <= pc_q;
              instr_pc4_q   <= pc_d;
              instr_valid_q <= 1'b1;
              state_q       <= HOLD;
            end
          end else if (redirect_i) begin
            pending_q <= 1'b1;
            pend_pc_q <= tgt;
            flush_q   <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            pc_q          <= pc_d;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b1;
            state_q       <= IDLE;
          end else if (!stall_i) begin
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            imem_addr_q   <= pc_q;
            state_q       <= WAIT;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end
  assign imem_req_o    = imem_req_q;
  assign imem_addr_o   = imem_addr_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_pc4_o   = instr_pc4_q;
  assign flush_o       = flush_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: vector table plus redirect/wrap/reset sequences with an instruction scoreboard
module tb_pc_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n, stall, redirect, imem_req, imem_ack, instr_valid, flush;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, instr_pc, instr_pc4;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4;} exp_t;
  typedef struct {int delay; int stall; logic [31:0] data; logic [31:0] addr;} vec_t;
  exp_t sb[$];
  vec_t vecs[5];
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .instr_o      (instr),
    .instr_valid_o(instr_valid),
    .instr_pc_o   (instr_pc),
    .instr_pc4_o  (instr_pc4),
    .flush_o      (flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (instr_valid && !prev_valid) begin
      if (sb.size() == 0) chk("sb_unexpected_valid", 32'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_instr_pc", instr_pc, e.pc);
        chk("sb_instr_pc4", instr_pc4, e.pc4);
      end
    end
    prev_valid = instr_valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", imem_req, 1);
  endtask

  task automatic check_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_pc4", instr_pc4, 0);
    chk("rst_flush", flush, 0);
  endtask

  task automatic do_vec(input vec_t v, input bit b2b);
    int n;
    wait_req(n);
    if (b2b) chk("b2b_gap", 32'(n), 1);
    chk("fetch_addr", imem_addr, v.addr);
    repeat (v.delay) begin
      tick();
      chk("addr_stable", imem_addr, v.addr);
    end
    imem_ack = 1'b1;
    imem_rdata = v.data;
    sb.push_back('{v.data, v.addr, v.addr + 32'd4});
    tick();
    imem_ack = 1'b0;
    chk("valid_after_ack", instr_valid, 1);
    stall = 1'b1;
    repeat (v.stall) begin
      imem_ack = 1'b1;
      imem_rdata = ~v.data;
      tick();
      chk("stall_pc", instr_pc, v.addr);
      chk("stall_instr", instr, v.data);
      chk("stall_no_req", imem_req, 0);
    end
    imem_ack = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    vecs[0] = '{0, 0, 32'h0000_0013, 32'h0};
    vecs[1] = '{0, 0, 32'h0040_0093, 32'h4};
    vecs[2] = '{0, 5, 32'h0080_0113, 32'h8};
    vecs[3] = '{0, 0, 32'h00C0_0193, 32'hC};
    vecs[4] = '{3, 0, 32'h0100_0213, 32'h10};
    tick(); tick();
    check_reset();
    rst_n = 1'b1;
    chk("boot_req", imem_req, 0);
    tick();
    chk("idle_req", imem_req, 0);
    tick();
    chk("req_3rd", imem_req, 1);
    chk("req_3rd_addr", imem_addr, 0);
    for (int i = 0; i < 5; i++) do_vec(vecs[i], i != 0);
    // redirect while waiting on a slow ack; low target bits are masked
    wait_req(n);
    chk("w_addr", imem_addr, 32'h14);
    redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect = 1'b0;
    chk("w_flush", flush, 1);
    chk("w_req_kept", imem_req, 1);
    chk("w_addr_kept", imem_addr, 32'h14);
    tick(); tick();
    chk("w_flush_once", flush, 0);
    chk("w_addr_kept2", imem_addr, 32'h14);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("w_discard", instr_valid, 0);
    chk("w_req_drop", imem_req, 0);
    wait_req(n);
    chk("w_new_addr", imem_addr, 32'h40);
    // redirect coincident with ack
    redirect = 1'b1; redirect_pc = 32'h60; imem_ack = 1'b1;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    chk("ra_flush", flush, 1);
    chk("ra_discard", instr_valid, 0);
    wait_req(n);
    chk("ra_addr", imem_addr, 32'h60);
    // two redirects before ack, newest wins
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    chk("dr_flush1", flush, 1);
    tick();
    chk("dr_flush_gap", flush, 0);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("dr_flush2", flush, 1);
    chk("dr_addr_kept", imem_addr, 32'h60);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("dr_discard", instr_valid, 0);
    do_vec('{0, 0, 32'hCAFE_0100, 32'h100}, 1'b0);
    // redirect in HOLD overrides stall and drops the held instruction
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    stall = 1'b0; redirect = 1'b0;
    chk("h_drop", instr_valid, 0);
    chk("h_flush", flush, 1);
    do_vec('{0, 0, 32'hCAFE_0200, 32'h200}, 1'b0);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    do_vec('{1, 2, 32'hCAFE_FFFC, 32'hFFFF_FFFC}, 1'b0);
    do_vec('{0, 0, 32'hCAFE_0000, 32'h0}, 1'b1);
    // reset mid-fetch; a redirect during BOOT is ignored
    wait_req(n);
    chk("mr_addr", imem_addr, 32'h4);
    rst_n = 1'b0;
    tick();
    check_reset();
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    chk("boot_redirect_flush", flush, 0);
    chk("mr_idle_req", imem_req, 0);
    tick();
    chk("mr_req", imem_req, 1);
    chk("mr_req_addr", imem_addr, 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
